// File: rtl/neuron_train_ctrl_pkg.sv
// Shared types and constants for the single-neuron training slice.
package neuron_pkg;

  // Sequencer states, one per step of the per-sample training loop.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    FETCH     = 3'd2,
    LOAD      = 3'd3,
    CALC      = 3'd4,
    UPDATE    = 3'd5,
    EPOCH_END = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Datapath widths: weights/bias and the sign output of the neuron.
  localparam int W_WIDTH  = 14;
  localparam int Y_SIGN_W = 2;

  // Default training set size and epoch limit.
  localparam int DEF_N_SAMPLES  = 4;
  localparam int DEF_MAX_EPOCHS = 64;

endpackage

// File: rtl/neuron_train_ctrl.sv
// Training sequencer: walks the sample memory, strobes the datapath through
// load/compute/update for every sample and counts epochs until the neuron
// converges (error-free epoch) or the epoch limit is reached.
module neuron_train_ctrl
  import neuron_pkg::*;
#(
  parameter int N_SAMPLES   = DEF_N_SAMPLES,
  parameter int ADDR_W      = 2,
  parameter int MAX_EPOCHS  = DEF_MAX_EPOCHS,
  parameter int EPOCH_W     = 7,
  parameter int CALC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               err,
  output logic               ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               clr_w,
  output logic               ld_x,
  output logic               calc,
  output logic               upd_en,
  output logic [EPOCH_W-1:0] epoch,
  output logic               converged,
  output logic               timeout
);

  // A one-cycle calc still needs a one-bit counter to keep the compare legal.
  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  ADDR_ZERO   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0]  ADDR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST   = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_ZERO  = EPOCH_W'(0);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE   = EPOCH_W'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_SAT   = {EPOCH_W{1'b1}};
  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);
  localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(CALC_CYCLES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] calc_cnt_r;
  logic             err_flag_r;    // any sample of the current epoch mispredicted
  logic             start_seen_r;  // start observed low while parked in DONE

  // Sequencer: next state plus registered Moore strobes for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ready        <= 1'b0;
      mem_rd       <= 1'b0;
      clr_w        <= 1'b0;
      ld_x         <= 1'b0;
      calc         <= 1'b0;
      upd_en       <= 1'b0;
      mem_addr     <= ADDR_ZERO;
      epoch        <= EPOCH_ZERO;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      calc_cnt_r   <= CNT_ZERO;
      err_flag_r   <= 1'b0;
      start_seen_r <= 1'b0;
    end else begin
      // Single-cycle strobes drop unless the entered state raises them again.
      mem_rd <= 1'b0;
      clr_w  <= 1'b0;
      ld_x   <= 1'b0;
      upd_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= INIT;
            ready        <= 1'b0;
            clr_w        <= 1'b1;
            mem_addr     <= ADDR_ZERO;
            epoch        <= EPOCH_ZERO;
            converged    <= 1'b0;
            timeout      <= 1'b0;
            err_flag_r   <= 1'b0;
            start_seen_r <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        INIT: begin
          state_r <= FETCH;
          mem_rd  <= 1'b1;
        end
        FETCH: begin
          state_r <= LOAD;
          ld_x    <= 1'b1;
        end
        LOAD: begin
          state_r    <= CALC;
          calc       <= 1'b1;
          calc_cnt_r <= CNT_ZERO;
        end
        CALC: begin
          // err is only meaningful in the final calc cycle; it becomes upd_en directly.
          if (calc_cnt_r == CNT_LAST) begin
            state_r <= UPDATE;
            calc    <= 1'b0;
            upd_en  <= err;
          end else begin
            calc_cnt_r <= calc_cnt_r + CNT_ONE;
          end
        end
        UPDATE: begin
          err_flag_r <= err_flag_r | upd_en;
          if (mem_addr == ADDR_LAST) begin
            state_r  <= EPOCH_END;
            mem_addr <= ADDR_ZERO;
          end else begin
            state_r  <= FETCH;
            mem_addr <= mem_addr + ADDR_ONE;
            mem_rd   <= 1'b1;
          end
        end
        EPOCH_END: begin
          if (epoch != EPOCH_SAT) begin
            epoch <= epoch + EPOCH_ONE;
          end else begin
            epoch <= epoch;
          end
          if (!err_flag_r) begin
            state_r   <= DONE;
            converged <= 1'b1;
            ready     <= 1'b1;
          end else if ((epoch + EPOCH_ONE) == EPOCH_LIMIT) begin
            state_r <= DONE;
            timeout <= 1'b1;
            ready   <= 1'b1;
          end else begin
            state_r    <= FETCH;
            err_flag_r <= 1'b0;
            mem_rd     <= 1'b1;
          end
        end
        DONE: begin
          // Park until start has been seen low so a held start cannot retrigger.
          ready <= 1'b1;
          if (start_seen_r) begin
            state_r      <= IDLE;
            start_seen_r <= 1'b0;
          end else if (!start) begin
            start_seen_r <= 1'b1;
          end else begin
            start_seen_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b0;
          calc    <= 1'b0;
        end
      endcase
    end
  end

endmodule
